l3_neuron_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one external combinational neuron datapath (N inputs, WIDTH-bit signed, instance kept outside this block) among NREQ independent requesters. Each requester submits one neuron job (x, w, b) over a valid/ready handshake. The block drives registered operands to the neuron, waits one evaluation cycle, captures the result, and returns it to the owning requester over a second valid/ready handshake. The block sits between serial network controllers (GAN layer sequencers) and the single shared neuron.

---
 rtl/l3_neuron_arbiter.sv | 128 ++++++++++++
 tb/tb_l3_neuron_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/l3_neuron_arbiter.sv
// Round-robin sequencer that time-shares one external combinational neuron
// among NREQ requesters. Each job is ARB (grant + operand capture),
// EVAL (sample ny) and RESP (hold the result until the owner accepts it).
module l3_neuron_arbiter #(
  parameter int NREQ  = 4,
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*N*WIDTH-1:0]   req_x,
  input  logic [NREQ*N*WIDTH-1:0]   req_w,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic [N*WIDTH-1:0]        nx,
  output logic [N*WIDTH-1:0]        nw,
  output logic [WIDTH-1:0]          nb,
  input  logic [WIDTH-1:0]          ny,
  output logic                      busy,
  output logic [15:0]               op_count
);

  typedef enum logic [1:0] {ARB, EVAL, RESP} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last;
  logic [ID_W-1:0]     gnt;
  logic                gnt_vld;
  logic [2*NREQ-1:0]   dbl;
  logic [NREQ-1:0]     rot;
  logic [N*WIDTH-1:0]  sel_x, sel_w;
  logic [WIDTH-1:0]    sel_b;
  logic                hs;
  logic                owner_rdy;

  // Rotating-priority search: rotate valids so bit 0 is requester last+1,
  // take the lowest set bit, then mux that requester's operands.
  always_comb begin
    dbl     = {req_valid, req_valid};
    rot     = NREQ'(dbl >> (int'(last) + 1));
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && rot[i]) begin
        gnt_vld = 1'b1;
        gnt     = ID_W'((int'(last) + 1 + i) % NREQ);
      end
    end
    sel_x = '0;
    sel_w = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == ID_W'(i)) begin
        sel_x = req_x[i*N*WIDTH +: N*WIDTH];
        sel_w = req_w[i*N*WIDTH +: N*WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign hs        = (state == ARB) && gnt_vld;
  // rsp_valid is one-hot on the owner in RESP, so masking filters non-owners.
  assign owner_rdy = |(rsp_ready & rsp_valid);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (hs) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (owner_rdy) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Outputs decoded from state: grant only while arbitrating
  always_comb begin
    req_ready = '0;
    if (state == ARB && gnt_vld) req_ready = NREQ'(1) << gnt;
    busy = (state != ARB);
  end

  // Operand capture, result sampling, response retirement and pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nx        <= '0;
      nw        <= '0;
      nb        <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_valid <= '0;
      op_count  <= '0;
      last      <= ID_W'(NREQ - 1);
    end else begin
      case (state)
        ARB: if (hs) begin
          nx     <= sel_x;
          nw     <= sel_w;
          nb     <= sel_b;
          rsp_id <= gnt;
        end
        EVAL: begin
          rsp_data  <= ny;
          rsp_valid <= NREQ'(1) << rsp_id;
        end
        RESP: if (owner_rdy) begin
          rsp_valid <= '0;
          last      <= rsp_id;
          op_count  <= op_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l3_neuron_arbiter.sv
// Directed bench for l3_neuron_arbiter with a neuron stub ny = nb + nx lane0.
module tb_l3_neuron_arbiter;
  localparam int NREQ = 4;
  localparam int N    = 4;
  localparam int W    = 16;
  localparam int ID_W = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*N*W-1:0]   req_x = '0;
  logic [NREQ*N*W-1:0]   req_w = '0;
  logic [NREQ*W-1:0]     req_b = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '0;
  logic [W-1:0]          rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic [N*W-1:0]        nx, nw;
  logic [W-1:0]          nb, ny;
  logic                  busy;
  logic [15:0]           op_count;

  int total = 0;
  int bad   = 0;

  assign ny = nb + nx[W-1:0];

  always #5 clk = ~clk;

  l3_neuron_arbiter #(.NREQ(NREQ), .N(N), .WIDTH(W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_w(req_w), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .nx(nx), .nw(nw), .nb(nb), .ny(ny),
    .busy(busy), .op_count(op_count)
  );

  typedef struct {
    logic [NREQ-1:0]        vmask;
    logic [NREQ*W-1:0]      x0;
    logic [NREQ*W-1:0]      b;
    logic [ID_W-1:0]        id;
    logic [W-1:0]           data;
    logic [15:0]            cnt;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic [NREQ-1:0] m, input logic [NREQ*W-1:0] x0,
                              input logic [NREQ*W-1:0] b, input logic [ID_W-1:0] id,
                              input logic [W-1:0] d, input logic [15:0] c);
    vec_t v;
    v.vmask = m; v.x0 = x0; v.b = b; v.id = id; v.data = d; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Lane 0 of x comes from the table; upper lanes and weights follow a fixed pattern
  task automatic drive(input logic [NREQ-1:0] m, input logic [NREQ*W-1:0] x0,
                       input logic [NREQ*W-1:0] b);
    req_valid = m;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < N; k++) begin
        req_x[(i*N+k)*W +: W] = (k == 0) ? x0[i*W +: W] : W'(32'hA000 + i*16 + k);
        req_w[(i*N+k)*W +: W] = W'(32'h1000 * (i + 1) + k);
      end
      req_b[i*W +: W] = b[i*W +: W];
    end
  endtask

  function automatic logic [N*W-1:0] exp_x(input int id, input logic [W-1:0] x0);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = (k == 0) ? x0 : W'(32'hA000 + id*16 + k);
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_w(input int id);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(32'h1000 * (id + 1) + k);
    return v;
  endfunction

  function automatic logic [NREQ-1:0] oh(input logic [ID_W-1:0] id);
    return NREQ'(1) << id;
  endfunction

  initial begin
    vec_t r;
    int   id;

    tbl[0] = mk(4'hF, 64'h0, 64'h0300_0200_0100_0000, 2'd0, 16'h0000, 16'd0);
    tbl[1] = mk(4'hF, 64'h0, 64'h0300_0200_0100_0000, 2'd1, 16'h0100, 16'd1);
    tbl[2] = mk(4'hF, 64'h0, 64'h0300_0200_0100_0000, 2'd2, 16'h0200, 16'd2);
    tbl[3] = mk(4'hF, 64'h0, 64'h0300_0200_0100_0000, 2'd3, 16'h0300, 16'd3);
    tbl[4] = mk(4'b0010, 64'h0000_0000_0005_0000, 64'h0000_0000_0010_0000, 2'd1, 16'h0015, 16'd4);
    tbl[5] = mk(4'b0100, 64'h0000_0003_0000_0000, 64'h0000_0020_0000_0000, 2'd2, 16'h0023, 16'd5);
    tbl[6] = mk(4'b1001, 64'h0002_0000_0000_0001, 64'h0040_0000_0000_0030, 2'd3, 16'h0042, 16'd6);
    tbl[7] = mk(4'b1001, 64'h0002_0000_0000_0001, 64'h0040_0000_0000_0030, 2'd0, 16'h0031, 16'd7);
    tbl[8] = mk(4'b0001, 64'h1, 64'h7FFF, 2'd0, 16'h8000, 16'd8);
    tbl[9] = mk(4'b0001, 64'h2, 64'hFFFF, 2'd0, 16'h0001, 16'd9);

    // Reset state
    #12;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_nx", 64'(nx), 64'h0);
    chk("rst_op_count", 64'(op_count), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: round-robin order, single job, fairness, data wrap
    for (int n = 0; n < 10; n++) begin
      r  = tbl[n];
      id = int'(r.id);
      @(negedge clk);
      drive(r.vmask, r.x0, r.b);
      rsp_ready = '1;
      #1;
      chk($sformatf("grant[%0d]", n), 64'(req_ready), 64'(oh(r.id)));
      chk($sformatf("cnt[%0d]", n), 64'(op_count), 64'(r.cnt));
      chk($sformatf("arb_busy[%0d]", n), 64'(busy), 64'h0);
      @(negedge clk);
      chk($sformatf("eval_busy[%0d]", n), 64'(busy), 64'h1);
      chk($sformatf("eval_rdy[%0d]", n), 64'(req_ready), 64'h0);
      chk($sformatf("eval_rspv[%0d]", n), 64'(rsp_valid), 64'h0);
      chk($sformatf("nx[%0d]", n), 64'(nx), 64'(exp_x(id, r.x0[id*W +: W])));
      chk($sformatf("nw[%0d]", n), 64'(nw), 64'(exp_w(id)));
      chk($sformatf("nb[%0d]", n), 64'(nb), 64'(r.b[id*W +: W]));
      @(negedge clk);
      chk($sformatf("rsp_valid[%0d]", n), 64'(rsp_valid), 64'(oh(r.id)));
      chk($sformatf("rsp_data[%0d]", n), 64'(rsp_data), 64'(r.data));
      chk($sformatf("rsp_id[%0d]", n), 64'(rsp_id), 64'(r.id));
    end

    // Backpressure: owner 0 holds off for 5 cycles, non-owner ready is ignored
    @(negedge clk);
    drive(4'b0001, 64'h7, 64'h0100);
    rsp_ready = '0;
    #1;
    chk("bp_grant", 64'(req_ready), 64'h1);
    chk("bp_cnt0", 64'(op_count), 64'd10);
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("bp_rsp_data", 64'(rsp_data), 64'h0107);
    rsp_ready = 4'b0100;
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(rsp_valid), 64'h1);
      chk("bp_hold_data", 64'(rsp_data), 64'h0107);
      chk("bp_hold_nx", 64'(nx), 64'(exp_x(0, 16'h0007)));
      chk("bp_hold_rdy", 64'(req_ready), 64'h0);
      chk("bp_hold_cnt", 64'(op_count), 64'd10);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    chk("bp_done_valid", 64'(rsp_valid), 64'h0);
    chk("bp_done_cnt", 64'(op_count), 64'd11);
    chk("bp_done_busy", 64'(busy), 64'h0);
    chk("bp_next_grant", 64'(req_ready), 64'h2);
    rsp_ready = '0;

    // Reset asserted in RESP discards the job and restores priority
    @(negedge clk);
    @(negedge clk);
    chk("rr_in_resp", 64'(rsp_valid), 64'h2);
    req_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("rr_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rr_busy", 64'(busy), 64'h0);
    chk("rr_nx", 64'(nx), 64'h0);
    chk("rr_nb", 64'(nb), 64'h0);
    chk("rr_rsp_data", 64'(rsp_data), 64'h0);
    chk("rr_rsp_id", 64'(rsp_id), 64'h0);
    chk("rr_op_count", 64'(op_count), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'hF, 64'h0004_0003_0002_0001, 64'h0);
    rsp_ready = '1;
    #1;
    chk("rr_first_grant", 64'(req_ready), 64'h1);
    chk("rr_cnt0", 64'(op_count), 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rr_rsp_id0", 64'(rsp_id), 64'h0);
    chk("rr_rsp_data0", 64'(rsp_data), 64'h0001);
    req_valid = '0;
    @(negedge clk);
    chk("rr_cnt1", 64'(op_count), 64'h1);

    // Counter wrap: preload 0xFFFF, then one more job
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    @(negedge clk);
    drive(4'b0100, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000);
    #1;
    chk("wrap_grant", 64'(req_ready), 64'h4);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("wrap_rsp_data", 64'(rsp_data), 64'h0003);
    @(negedge clk);
    chk("wrap_cnt", 64'(op_count), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
